// File: rtl/rv32i_commit_checker_if.sv
// rtl/rv32i_commit_checker_if.sv - commit record streams and verdict signals of the lockstep checker
// master drives the two retire streams and eot; slave is the checker itself.
interface rv32i_commit_checker_if;
   logic        ref_valid;
   logic [31:0] ref_pc;
   logic [31:0] ref_instr;
   logic        ref_rd_we;
   logic [4:0]  ref_rd;
   logic [31:0] ref_rd_data;
   logic        dut_valid;
   logic [31:0] dut_pc;
   logic [31:0] dut_instr;
   logic        dut_rd_we;
   logic [4:0]  dut_rd;
   logic [31:0] dut_rd_data;
   logic        eot;
   logic        ref_run;
   logic        pass;
   logic        fail;
   logic [2:0]  fail_cause;
   logic [31:0] match_cnt;
   logic [31:0] mm_ref_pc;
   logic [31:0] mm_dut_pc;

   modport master (
      output ref_valid, ref_pc, ref_instr, ref_rd_we, ref_rd, ref_rd_data,
      output dut_valid, dut_pc, dut_instr, dut_rd_we, dut_rd, dut_rd_data,
      output eot,
      input  ref_run, pass, fail, fail_cause, match_cnt, mm_ref_pc, mm_dut_pc
   );

   modport slave (
      input  ref_valid, ref_pc, ref_instr, ref_rd_we, ref_rd, ref_rd_data,
      input  dut_valid, dut_pc, dut_instr, dut_rd_we, dut_rd, dut_rd_data,
      input  eot,
      output ref_run, pass, fail, fail_cause, match_cnt, mm_ref_pc, mm_dut_pc
   );
endinterface

// File: rtl/rv32i_commit_checker.sv
// rtl/rv32i_commit_checker.sv - lockstep retire-record checker between the rv32i reference model and a core
// Index 0 of every per-side array is the reference model, index 1 the core under test.
module rv32i_commit_checker #(
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 1000
) (
   input logic clk,
   input logic rst_n,
   rv32i_commit_checker_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int RW = 102;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] RUN_MAX  = CW'(DEPTH - 2);
   localparam logic [31:0]   TO_LAST  = 32'(TIMEOUT - 1);

   typedef enum logic [1:0] {RUN, DRAIN, PASS, FAIL} state_t;
   state_t state, state_next;

   logic [RW-1:0] mem   [2][DEPTH];
   logic [AW-1:0] wptr  [2];
   logic [AW-1:0] rptr  [2];
   logic [CW-1:0] cnt   [2];
   logic [RW-1:0] wdata [2];
   logic [RW-1:0] rdata [2];
   logic [1:0]    valid, empty, full, push, ovf;
   logic          active, pop, exactly_one;

   logic          cmp_valid;
   logic [RW-1:0] cmp_ref, cmp_dut;
   logic          pc_mm, instr_mm, rd_mm, cmp_eq;

   logic [31:0]   to_cnt;
   logic          to_hit;
   logic          left_seen, left_hit;
   logic [2:0]    cause_now, fail_cause_q;
   logic [31:0]   match_q, mm_ref_q, mm_dut_q;

   // Record layout {pc[101:70], instr[69:38], rd_we[37], rd[36:32], rd_data[31:0]}
   assign valid    = {bus.dut_valid, bus.ref_valid};
   assign wdata[0] = {bus.ref_pc, bus.ref_instr, bus.ref_rd_we, bus.ref_rd, bus.ref_rd_data};
   assign wdata[1] = {bus.dut_pc, bus.dut_instr, bus.dut_rd_we, bus.dut_rd, bus.dut_rd_data};
   assign active   = (state == RUN) || (state == DRAIN);

   always_comb begin
      for (int s = 0; s < 2; s++) begin
         empty[s] = (cnt[s] == '0);
         full[s]  = (cnt[s] == FULL_CNT);
         rdata[s] = mem[s][rptr[s]];
      end
      pop = active && !empty[0] && !empty[1];
      // A full FIFO still accepts a push when the same cycle pops it.
      for (int s = 0; s < 2; s++) begin
         push[s] = active && valid[s] && (!full[s] || pop);
         ovf[s]  = active && valid[s] && full[s] && !pop;
      end
      exactly_one = empty[0] ^ empty[1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < 2; s++) begin
            wptr[s] <= '0;
            rptr[s] <= '0;
            cnt[s]  <= '0;
         end
      end else begin
         for (int s = 0; s < 2; s++) begin
            if (push[s]) wptr[s] <= wptr[s] + AW'(1);
            if (pop)     rptr[s] <= rptr[s] + AW'(1);
            if (push[s] && !pop)      cnt[s] <= cnt[s] + CW'(1);
            else if (!push[s] && pop) cnt[s] <= cnt[s] - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int s = 0; s < 2; s++) begin
         if (push[s]) mem[s][wptr[s]] <= wdata[s];
      end
   end

   always_comb begin
      pc_mm    = cmp_valid && (cmp_ref[101:70] != cmp_dut[101:70]);
      instr_mm = cmp_valid && (cmp_ref[69:38] != cmp_dut[69:38]);
      // rd and rd_data only matter when the instruction actually writes rd
      rd_mm    = cmp_valid && ((cmp_ref[37] != cmp_dut[37]) ||
                               (cmp_ref[37] && (cmp_ref[36:0] != cmp_dut[36:0])));
      cmp_eq   = cmp_valid && !pc_mm && !instr_mm && !rd_mm;
      to_hit   = exactly_one && (to_cnt >= TO_LAST);
      left_hit = (state == DRAIN) && exactly_one && left_seen;
      cause_now = 3'd0;
      if (active) begin
         if (pc_mm)         cause_now = 3'd1;
         else if (instr_mm) cause_now = 3'd2;
         else if (rd_mm)    cause_now = 3'd3;
         else if (ovf[0])   cause_now = 3'd4;
         else if (ovf[1])   cause_now = 3'd5;
         else if (to_hit)   cause_now = 3'd6;
         else if (left_hit) cause_now = 3'd7;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RUN;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         RUN: begin
            if (cause_now != 3'd0) state_next = FAIL;
            else if (bus.eot)      state_next = DRAIN;
         end
         DRAIN: begin
            if (cause_now != 3'd0)                state_next = FAIL;
            else if (empty == 2'b11 && !cmp_valid) state_next = PASS;
         end
         default: state_next = state;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmp_valid    <= 1'b0;
         cmp_ref      <= '0;
         cmp_dut      <= '0;
         to_cnt       <= '0;
         left_seen    <= 1'b0;
         fail_cause_q <= '0;
         match_q      <= '0;
         mm_ref_q     <= '0;
         mm_dut_q     <= '0;
      end else begin
         cmp_valid <= pop;
         if (pop) begin
            cmp_ref <= rdata[0];
            cmp_dut <= rdata[1];
         end
         if (active && exactly_one) begin
            if (to_cnt != '1) to_cnt <= to_cnt + 32'd1;
         end else begin
            to_cnt <= '0;
         end
         left_seen <= (state == DRAIN) && exactly_one;
         if (active && cmp_eq && (match_q != '1)) match_q <= match_q + 32'd1;
         if (cause_now != 3'd0) begin
            fail_cause_q <= cause_now;
            if (cause_now <= 3'd3) begin
               mm_ref_q <= cmp_ref[101:70];
               mm_dut_q <= cmp_dut[101:70];
            end
         end
      end
   end

   assign bus.ref_run    = active && (cnt[0] <= RUN_MAX);
   assign bus.pass       = (state == PASS);
   assign bus.fail       = (state == FAIL);
   assign bus.fail_cause = fail_cause_q;
   assign bus.match_cnt  = match_q;
   assign bus.mm_ref_pc  = mm_ref_q;
   assign bus.mm_dut_pc  = mm_dut_q;
endmodule

// File: tb/tb_rv32i_commit_checker.sv
// tb/tb_rv32i_commit_checker.sv - directed self-checking bench for rv32i_commit_checker
// One DUT with DEPTH 16 and TIMEOUT 20 serves every scenario.
module tb_rv32i_commit_checker;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   rv32i_commit_checker_if bus();

   rv32i_commit_checker #(.DEPTH(16), .TIMEOUT(20)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ref(input bit v, input int i);
      bus.ref_valid   = v;
      bus.ref_pc      = 32'(i * 4);
      bus.ref_instr   = 32'h0000_0013 | (32'(i) << 20);
      bus.ref_rd_we   = 1'b1;
      bus.ref_rd      = 5'(i);
      bus.ref_rd_data = 32'h1000 + 32'(i);
   endtask

   task automatic set_dut(input bit v, input int i);
      bus.dut_valid   = v;
      bus.dut_pc      = 32'(i * 4);
      bus.dut_instr   = 32'h0000_0013 | (32'(i) << 20);
      bus.dut_rd_we   = 1'b1;
      bus.dut_rd      = 5'(i);
      bus.dut_rd_data = 32'h1000 + 32'(i);
   endtask

   task automatic idle();
      set_ref(1'b0, 0);
      set_dut(1'b0, 0);
      bus.eot = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_done(input int max_cycles, input string name);
      int k = 0;
      while (!(bus.pass || bus.fail) && k < max_cycles) begin
         tick();
         k++;
      end
      n_checks++;
      if (!(bus.pass || bus.fail)) begin
         n_fail++;
         $display("FAIL %s: no verdict after %0d cycles, required within %0d", name, k, max_cycles);
      end
   endtask

   task automatic test_reset();
      idle();
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (bus.ref_run !== 1'b1) begin n_fail++; $display("FAIL reset_ref_run: got %0b, expected 1", bus.ref_run); end
      n_checks++; if (bus.pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass: got %0b, expected 0", bus.pass); end
      n_checks++; if (bus.fail !== 1'b0) begin n_fail++; $display("FAIL reset_fail: got %0b, expected 0", bus.fail); end
      n_checks++; if (bus.fail_cause !== 3'd0) begin n_fail++; $display("FAIL reset_cause: got %0d, expected 0", bus.fail_cause); end
      n_checks++; if (bus.match_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_match: got %0d, expected 0", bus.match_cnt); end
      n_checks++; if ({bus.mm_ref_pc, bus.mm_dut_pc} !== 64'd0) begin n_fail++; $display("FAIL reset_mm: got %0h/%0h, expected 0/0", bus.mm_ref_pc, bus.mm_dut_pc); end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_identical();
      do_reset();
      for (int i = 0; i < 100; i++) begin
         set_ref(1'b1, i);
         set_dut(1'b1, i);
         tick();
      end
      idle();
      bus.eot = 1'b1;
      wait_done(3, "identical_latency");
      n_checks++; if (bus.pass !== 1'b1) begin n_fail++; $display("FAIL identical_pass: got %0b, expected 1", bus.pass); end
      n_checks++; if (bus.fail !== 1'b0) begin n_fail++; $display("FAIL identical_fail: got %0b, expected 0", bus.fail); end
      n_checks++; if (bus.match_cnt !== 32'd100) begin n_fail++; $display("FAIL identical_match: got %0d, expected 100", bus.match_cnt); end
      bus.eot = 1'b0;
   endtask

   task automatic test_skewed();
      do_reset();
      for (int c = 0; c < 57; c++) begin
         set_ref(c < 50, c);
         set_dut(c >= 7, c - 7);
         tick();
         n_checks++; if (bus.ref_run !== 1'b1) begin n_fail++; $display("FAIL skew_ref_run cycle %0d: got %0b, expected 1", c, bus.ref_run); end
         n_checks++; if (bus.fail !== 1'b0) begin n_fail++; $display("FAIL skew_no_fail cycle %0d: got %0b, expected 0", c, bus.fail); end
      end
      idle();
      bus.eot = 1'b1;
      wait_done(5, "skew_latency");
      n_checks++; if (bus.pass !== 1'b1) begin n_fail++; $display("FAIL skew_pass: got %0b, expected 1", bus.pass); end
      n_checks++; if (bus.match_cnt !== 32'd50) begin n_fail++; $display("FAIL skew_match: got %0d, expected 50", bus.match_cnt); end
      bus.eot = 1'b0;
   endtask

   task automatic test_data_mismatch();
      do_reset();
      for (int i = 0; i <= 10; i++) begin
         set_ref(1'b1, i);
         set_dut(1'b1, i);
         if (i == 10) begin
            bus.ref_rd_data = 32'h5;
            bus.dut_rd_data = 32'h6;
         end
         tick();
      end
      idle();
      wait_done(4, "data_mm_latency");
      n_checks++; if (bus.fail !== 1'b1) begin n_fail++; $display("FAIL data_mm_fail: got %0b, expected 1", bus.fail); end
      n_checks++; if (bus.fail_cause !== 3'd3) begin n_fail++; $display("FAIL data_mm_cause: got %0d, expected 3", bus.fail_cause); end
      n_checks++; if (bus.mm_ref_pc !== 32'h28) begin n_fail++; $display("FAIL data_mm_ref_pc: got %0h, expected 28", bus.mm_ref_pc); end
      n_checks++; if (bus.mm_dut_pc !== 32'h28) begin n_fail++; $display("FAIL data_mm_dut_pc: got %0h, expected 28", bus.mm_dut_pc); end
      n_checks++; if (bus.match_cnt !== 32'd10) begin n_fail++; $display("FAIL data_mm_match: got %0d, expected 10", bus.match_cnt); end
      n_checks++; if (bus.pass !== 1'b0) begin n_fail++; $display("FAIL data_mm_pass: got %0b, expected 0", bus.pass); end
   endtask

   task automatic test_rd_we_zero();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_ref(1'b1, i);
         set_dut(1'b1, i);
         bus.ref_rd_we   = 1'b0;
         bus.dut_rd_we   = 1'b0;
         bus.dut_rd      = bus.ref_rd + 5'd1;
         bus.dut_rd_data = ~bus.ref_rd_data;
         tick();
      end
      idle();
      bus.eot = 1'b1;
      wait_done(4, "rdwe0_latency");
      n_checks++; if (bus.pass !== 1'b1) begin n_fail++; $display("FAIL rdwe0_pass: got %0b, expected 1", bus.pass); end
      n_checks++; if (bus.match_cnt !== 32'd4) begin n_fail++; $display("FAIL rdwe0_match: got %0d, expected 4", bus.match_cnt); end
      bus.eot = 1'b0;
   endtask

   task automatic test_pc_priority();
      do_reset();
      set_ref(1'b1, 64);
      set_dut(1'b1, 65);
      tick();
      idle();
      wait_done(4, "pc_mm_latency");
      n_checks++; if (bus.fail_cause !== 3'd1) begin n_fail++; $display("FAIL pc_mm_cause: got %0d, expected 1", bus.fail_cause); end
      n_checks++; if (bus.mm_ref_pc !== 32'h100) begin n_fail++; $display("FAIL pc_mm_ref_pc: got %0h, expected 100", bus.mm_ref_pc); end
      n_checks++; if (bus.mm_dut_pc !== 32'h104) begin n_fail++; $display("FAIL pc_mm_dut_pc: got %0h, expected 104", bus.mm_dut_pc); end
      n_checks++; if (bus.match_cnt !== 32'd0) begin n_fail++; $display("FAIL pc_mm_match: got %0d, expected 0", bus.match_cnt); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 17; i++) begin
         set_ref(1'b1, i);
         tick();
         if (i == 15) begin
            n_checks++; if (bus.fail !== 1'b0) begin n_fail++; $display("FAIL ovf_full_no_fail: got %0b, expected 0", bus.fail); end
         end
      end
      n_checks++; if (bus.fail !== 1'b1) begin n_fail++; $display("FAIL ovf_fail: got %0b, expected 1", bus.fail); end
      n_checks++; if (bus.fail_cause !== 3'd4) begin n_fail++; $display("FAIL ovf_cause: got %0d, expected 4", bus.fail_cause); end
      set_dut(1'b1, 0);
      tick();
      tick();
      idle();
      n_checks++; if (bus.fail_cause !== 3'd4) begin n_fail++; $display("FAIL ovf_hold_cause: got %0d, expected 4", bus.fail_cause); end
      n_checks++; if ({bus.mm_ref_pc, bus.mm_dut_pc} !== 64'd0) begin n_fail++; $display("FAIL ovf_mm: got %0h/%0h, expected 0/0", bus.mm_ref_pc, bus.mm_dut_pc); end
      n_checks++; if (bus.ref_run !== 1'b0) begin n_fail++; $display("FAIL ovf_ref_run: got %0b, expected 0", bus.ref_run); end
      n_checks++; if (bus.match_cnt !== 32'd0) begin n_fail++; $display("FAIL ovf_match: got %0d, expected 0", bus.match_cnt); end
   endtask

   task automatic test_timeout();
      do_reset();
      set_ref(1'b1, 0);
      tick();
      for (int e = 1; e <= 20; e++) begin
         set_ref(bus.ref_run, e);
         tick();
         if (e == 19) begin
            n_checks++; if (bus.fail !== 1'b0) begin n_fail++; $display("FAIL to_early: got %0b at cycle 19, expected 0", bus.fail); end
         end
      end
      idle();
      n_checks++; if (bus.fail !== 1'b1) begin n_fail++; $display("FAIL to_fail: got %0b at cycle 20, expected 1", bus.fail); end
      n_checks++; if (bus.fail_cause !== 3'd6) begin n_fail++; $display("FAIL to_cause: got %0d, expected 6", bus.fail_cause); end
   endtask

   task automatic test_leftover();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         set_ref(1'b1, i);
         tick();
      end
      idle();
      bus.eot = 1'b1;
      wait_done(5, "left_latency");
      bus.eot = 1'b0;
      n_checks++; if (bus.fail !== 1'b1) begin n_fail++; $display("FAIL left_fail: got %0b, expected 1", bus.fail); end
      n_checks++; if (bus.fail_cause !== 3'd7) begin n_fail++; $display("FAIL left_cause: got %0d, expected 7", bus.fail_cause); end
      n_checks++; if (bus.mm_ref_pc !== 32'd0) begin n_fail++; $display("FAIL left_mm: got %0h, expected 0", bus.mm_ref_pc); end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         set_ref(1'b1, i);
         set_dut(1'b1, i);
         tick();
      end
      n_checks++; if (bus.match_cnt !== 32'd3) begin n_fail++; $display("FAIL mid_pre_match: got %0d, expected 3", bus.match_cnt); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus.match_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_match: got %0d, expected 0", bus.match_cnt); end
      n_checks++; if (bus.ref_run !== 1'b1) begin n_fail++; $display("FAIL mid_ref_run: got %0b, expected 1", bus.ref_run); end
      n_checks++; if ({bus.pass, bus.fail, bus.fail_cause} !== 5'd0) begin n_fail++; $display("FAIL mid_verdict: got %0h, expected 0", {bus.pass, bus.fail, bus.fail_cause}); end
      idle();
      #3 rst_n = 1'b1;
      tick();
      bus.eot = 1'b1;
      wait_done(4, "mid_latency");
      bus.eot = 1'b0;
      n_checks++; if (bus.pass !== 1'b1) begin n_fail++; $display("FAIL mid_post_pass: got %0b, expected 1", bus.pass); end
      n_checks++; if (bus.match_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_post_match: got %0d, expected 0", bus.match_cnt); end
   endtask

   initial begin
      test_reset();
      test_identical();
      test_skewed();
      test_data_mismatch();
      test_rd_we_zero();
      test_pc_priority();
      test_overflow();
      test_timeout();
      test_leftover();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
